// File: rtl/video_copper.sv
// Raster-synchronised register sequencer: walks a command list each frame and
// writes video IO registers at programmed scanlines. Optional: VIDEO_COPPER_HPOS_EN.
module video_copper #(
  parameter int unsigned LIST_DEPTH = 64,
  localparam int unsigned PTR_W = $clog2(LIST_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       vpos,
  input  logic [9:0]       hpos,
  input  logic             vblank,
  input  logic [7:0]       lst_addr,
  input  logic [7:0]       lst_wrdata,
  input  logic             lst_wren,
  output logic [7:0]       lst_rddata,
  input  logic [3:0]       cpu_io_addr,
  input  logic [7:0]       cpu_io_wrdata,
  input  logic             cpu_io_wren,
  output logic [3:0]       io_addr,
  output logic [7:0]       io_wrdata,
  output logic             io_wren,
  output logic             busy,
  output logic [PTR_W-1:0] cur_ptr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             vblank_q;
  logic             busy_q;
  logic [31:0]      ent_q;
  logic [3:0][7:0]  mem [LIST_DEPTH];

  logic             frame_start_c;
  logic             vblank_rise_c;
  logic             match_c;
  logic             cop_wr_c;
  logic             cop_go_c;
  logic             unused_c;
  logic [PTR_W-1:0] cpu_idx_c;

  logic [7:0]       ent_line_c;
  logic [3:0]       ent_reg_c;
  logic             ent_wait_only_c;
  logic             ent_end_c;
  logic [7:0]       ent_data_c;

  assign cpu_idx_c       = lst_addr[PTR_W+1:2];
  assign ent_line_c      = ent_q[7:0];
  assign ent_reg_c       = ent_q[11:8];
  assign ent_wait_only_c = ent_q[12];
  assign ent_end_c       = ent_q[15];
  assign ent_data_c      = ent_q[23:16];

  assign frame_start_c = vblank_q & ~vblank;
  assign vblank_rise_c = ~vblank_q & vblank;

`ifdef VIDEO_COPPER_HPOS_EN
  assign match_c  = (vpos > ent_line_c) ||
                    ((vpos == ent_line_c) && (hpos[9:2] >= ent_q[31:24]));
  assign unused_c = ^{hpos[1:0], ent_q[14:13]};
`else
  assign match_c  = (vpos >= ent_line_c);
  assign unused_c = ^{hpos, ent_q[31:24], ent_q[14:13]};
`endif

  // List RAM: CPU byte port plus a whole-entry sequencer port; contents survive reset
  always_ff @(posedge clk) begin
    if (lst_wren) begin
      mem[cpu_idx_c][lst_addr[1:0]] <= lst_wrdata;
    end
    lst_rddata <= mem[cpu_idx_c][lst_addr[1:0]];
    if (state_q == S_FETCH) begin
      ent_q <= mem[ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      vblank_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      vblank_q <= vblank;
      busy_q   <= (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_WRITE);
    end
  end

  // Next state: enable loss beats frame start, which beats the vblank abort
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cop_wr_c = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (frame_start_c) begin
      state_d = S_FETCH;
      ptr_d   = '0;
    end else if (vblank_rise_c &&
                 ((state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_WRITE))) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (match_c) begin
            if (ent_end_c) begin
              state_d = S_DONE;
            end else if (ent_wait_only_c) begin
              if (ptr_q == PTR_W'(LIST_DEPTH - 1)) begin
                state_d = S_DONE;
              end else begin
                ptr_d   = ptr_q + PTR_W'(1);
                state_d = S_FETCH;
              end
            end else begin
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (!cpu_io_wren) begin
            cop_wr_c = 1'b1;
            if (ptr_q == PTR_W'(LIST_DEPTH - 1)) begin
              state_d = S_DONE;
            end else begin
              ptr_d   = ptr_q + PTR_W'(1);
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Shared write port: CPU passes through unless the copper owns this cycle
  assign cop_go_c  = cop_wr_c & ~reset;
  assign io_addr   = cop_go_c ? ent_reg_c  : cpu_io_addr;
  assign io_wrdata = cop_go_c ? ent_data_c : cpu_io_wrdata;
  assign io_wren   = cop_go_c | cpu_io_wren;
  assign busy      = busy_q;
  assign cur_ptr   = ptr_q;

endmodule
